// File: rtl/td4_pkg.sv
// Types shared by the TD4 step generator, mother board and status LED logic.
package td4_pkg;

    typedef enum logic [1:0] {
        MODE_SLOW   = 2'b00,
        MODE_FAST   = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_HALT   = 2'b11
    } run_mode_e;

    function automatic logic is_timed(run_mode_e m);
        return (m == MODE_SLOW) || (m == MODE_FAST);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser, counter-based debounce,
// accepted level plus a 1-cycle pulse on each accepted 0->1 edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic          b1, b2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b1    <= 1'b0;
            b2    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            b1   <= btn;
            b2   <= b1;
            rise <= 1'b0;
            // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample.
            if (b2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                rise  <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_step_gen.sv
// TD4 timing front end: turns the board clock into a 1-cycle cpu_tick enable
// (1 Hz / 10 Hz / debounced single step / halt) and synchronises the DIP switches.
module clock_step_gen
    import td4_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int SLOW_HZ         = 1,
    parameter int FAST_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_sel,
    input  logic       step_btn,
    input  logic [3:0] switch_raw,
    output logic [3:0] switch_sync,
    output logic       cpu_tick,
    output logic [1:0] run_mode
);

    localparam int SLOW_P = CLK_HZ / SLOW_HZ;
    localparam int FAST_P = CLK_HZ / FAST_HZ;
    localparam int DIV_W  = $clog2(SLOW_P);

    generate
        if ((CLK_HZ % SLOW_HZ) != 0 || (CLK_HZ % FAST_HZ) != 0) begin : g_bad_div
            $error("clock_step_gen: SLOW_HZ and FAST_HZ must divide CLK_HZ");
        end
        if (SLOW_P < 2 || FAST_P < 2) begin : g_bad_period
            $error("clock_step_gen: tick period must be at least 2 cycles");
        end
        if (FAST_P > (1 << DIV_W)) begin : g_bad_width
            $error("clock_step_gen: FAST period does not fit the divider");
        end
    endgenerate

    logic [1:0]       mode_s1;
    run_mode_e        mode_q;
    logic [3:0]       sw_s1;
    logic [DIV_W-1:0] div;
    logic             btn_level, btn_rise;
    logic             mode_chg, wrap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clock (clock),
        .reset (reset),
        .btn   (step_btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // A change is seen on the edge that loads the new mode, so the divider
    // restarts together with it and the old mode's pending tick is dropped.
    assign mode_chg = run_mode_e'(mode_s1) != mode_q;

    always_comb begin
        wrap = 1'b0;
        case (mode_q)
            MODE_SLOW: wrap = (div == DIV_W'(SLOW_P - 1));
            MODE_FAST: wrap = (div == DIV_W'(FAST_P - 1));
            default:   wrap = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_s1     <= 2'b00;
            mode_q      <= MODE_SLOW;
            sw_s1       <= 4'h0;
            switch_sync <= 4'h0;
            div         <= '0;
            cpu_tick    <= 1'b0;
        end else begin
            mode_s1     <= mode_sel;
            mode_q      <= run_mode_e'(mode_s1);
            sw_s1       <= switch_raw;
            switch_sync <= sw_s1;

            if (mode_chg || wrap || !is_timed(mode_q))
                div <= '0;
            else
                div <= div + DIV_W'(1);

            cpu_tick <= !mode_chg &&
                        (wrap || (mode_q == MODE_MANUAL && btn_rise && btn_level));
        end
    end

    assign run_mode = mode_q;

endmodule
